// File: rtl/clock_mode_controller_pkg.sv
// Shared definitions for the digital-clock timekeeping slice.
//   mode_e  : mode FSM encoding, also the value presented on the mode port
//   BCD_W   : width of a two-digit packed BCD field {tens, units}
//   bcd_of  : converts a small integer (0..99) to packed two-digit BCD
package clock_mode_controller_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  localparam int unsigned BCD_W   = 8;
  localparam int unsigned DIGIT_W = 4;

  function automatic logic [BCD_W-1:0] bcd_of(input int unsigned v);
    return {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
  endfunction

endpackage

// File: rtl/clock_mode_controller_bcd_mod_counter.sv
// Two-digit BCD modulo counter, counts 00..MAX then wraps to 00.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset, clears to 00
//   i_inc    : advance by one this edge
//   i_clr    : force 00 this edge (wins over i_inc)
//   o_value  : {tens, units} BCD
//   o_carry  : high while i_inc will wrap MAX -> 00 on this edge
module bcd_mod_counter
  import clock_mode_controller_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [BCD_W-1:0] o_value,
  output logic             o_carry
);

  localparam logic [BCD_W-1:0] MAX_BCD = bcd_of(MAX);

  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_units;
  logic               w_at_max;

  assign w_at_max = ({r_tens, r_units} == MAX_BCD);
  assign o_carry  = i_inc & ~i_clr & w_at_max;
  assign o_value  = {r_tens, r_units};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_clr) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens  <= '0;
        r_units <= '0;
      end else if (r_units >= DIGIT_W'(9)) begin
        // >= keeps the digit legal even if it was ever disturbed
        r_units <= '0;
        r_tens  <= r_tens + DIGIT_W'(1);
      end else begin
        r_units <= r_units + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// Timekeeping and RUN / SET_HR / SET_MIN mode sequencer for the digital clock.
//   clk_50MHz   : system clock, rising edge
//   set_n       : asynchronous active-low reset
//   tick_1hz    : 1 Hz level from the clock divider (already in this domain)
//   key_mode_n  : mode key, active-low, asynchronous
//   key_inc_n   : increment key, active-low, asynchronous
//   hours_bcd   : {tens,units} 00..MAX_HOUR
//   minutes_bcd : {tens,units} 00..59
//   seconds_bcd : {tens,units} 00..59
//   mode        : 00 RUN, 01 SET_HR, 10 SET_MIN
//   blink       : blank phase for the field being set, 0 in RUN
//   div_set_n   : divider reset, held low after reset and after leaving SET_MIN
module clock_mode_controller
  import clock_mode_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DIV_CLR_CYCLES = 4,
  parameter int unsigned MAX_HOUR       = 23
) (
  input  logic             clk_50MHz,
  input  logic             set_n,
  input  logic             tick_1hz,
  input  logic             key_mode_n,
  input  logic             key_inc_n,
  output logic [BCD_W-1:0] hours_bcd,
  output logic [BCD_W-1:0] minutes_bcd,
  output logic [BCD_W-1:0] seconds_bcd,
  output logic [1:0]       mode,
  output logic             blink,
  output logic             div_set_n
);

  localparam int unsigned          CNT_W    = $clog2(DIV_CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CLR_LOAD = CNT_W'(DIV_CLR_CYCLES);

  logic [SYNC_STAGES-1:0] r_mode_sync, r_inc_sync;
  logic                   r_mode_hist, r_inc_hist;
  logic                   r_tick_q, r_tick_qq;
  logic [CNT_W-1:0]       r_div_cnt;
  logic                   r_blink;
  mode_e                  r_state, w_state_nxt;

  logic w_mode_press, w_inc_press, w_inc_act;
  logic w_tick_rise, w_tick_ok, w_div_ok;
  logic w_run, w_set_hr, w_set_min;
  logic w_sec_inc, w_sec_clr, w_min_inc, w_hr_inc;
  logic w_sec_carry, w_min_carry, w_hr_carry_unused;

  // Key synchronisers plus one history flop each; idle level is 1
  always_ff @(posedge clk_50MHz or negedge set_n) begin
    if (!set_n) begin
      r_mode_sync <= '1;
      r_inc_sync  <= '1;
      r_mode_hist <= 1'b1;
      r_inc_hist  <= 1'b1;
    end else begin
      r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], key_mode_n};
      r_inc_sync  <= {r_inc_sync[SYNC_STAGES-2:0], key_inc_n};
      r_mode_hist <= r_mode_sync[SYNC_STAGES-1];
      r_inc_hist  <= r_inc_sync[SYNC_STAGES-1];
    end
  end

  assign w_mode_press = ~r_mode_sync[SYNC_STAGES-1] & r_mode_hist;
  assign w_inc_press  = ~r_inc_sync[SYNC_STAGES-1] & r_inc_hist;
  assign w_inc_act    = w_inc_press & ~w_mode_press;

  always_ff @(posedge clk_50MHz or negedge set_n) begin
    if (!set_n) begin
      r_tick_q  <= 1'b0;
      r_tick_qq <= 1'b0;
    end else begin
      r_tick_q  <= tick_1hz;
      r_tick_qq <= r_tick_q;
    end
  end

  assign w_tick_rise = r_tick_q & ~r_tick_qq;
  assign w_div_ok    = (r_div_cnt == '0);
  assign w_tick_ok   = w_tick_rise & w_div_ok;

  // Mode FSM: state register
  always_ff @(posedge clk_50MHz or negedge set_n) begin
    if (!set_n) r_state <= MODE_RUN;
    else        r_state <= w_state_nxt;
  end

  // Mode FSM: next state (unused encoding falls back to RUN)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MODE_RUN:     if (w_mode_press) w_state_nxt = MODE_SET_HR;
      MODE_SET_HR:  if (w_mode_press) w_state_nxt = MODE_SET_MIN;
      MODE_SET_MIN: if (w_mode_press) w_state_nxt = MODE_RUN;
      default:      w_state_nxt = MODE_RUN;
    endcase
  end

  // Mode FSM: outputs
  always_comb begin
    w_run     = 1'b0;
    w_set_hr  = 1'b0;
    w_set_min = 1'b0;
    mode      = MODE_RUN;
    case (r_state)
      MODE_RUN:     w_run = 1'b1;
      MODE_SET_HR:  begin w_set_hr  = 1'b1; mode = MODE_SET_HR;  end
      MODE_SET_MIN: begin w_set_min = 1'b1; mode = MODE_SET_MIN; end
      default:      mode = MODE_RUN;
    endcase
  end

  // Divider hold: reloaded on SET_MIN -> RUN so the first second is full length
  always_ff @(posedge clk_50MHz or negedge set_n) begin
    if (!set_n)                        r_div_cnt <= CLR_LOAD;
    else if (w_set_min & w_mode_press) r_div_cnt <= CLR_LOAD;
    else if (!w_div_ok)                r_div_cnt <= r_div_cnt - CNT_W'(1);
  end

  assign div_set_n = w_div_ok;

  always_ff @(posedge clk_50MHz or negedge set_n) begin
    if (!set_n)                                      r_blink <= 1'b0;
    else if (w_mode_press | ~(w_set_hr | w_set_min)) r_blink <= 1'b0;
    else if (w_tick_ok)                              r_blink <= ~r_blink;
  end

  assign blink = r_blink;

  // Carries chain only in RUN; a set-mode increment never reaches the next field.
  // Entering SET_HR clears seconds and swallows a coincident tick.
  assign w_sec_clr = w_run & w_mode_press;
  assign w_sec_inc = w_run & w_tick_ok & ~w_mode_press;
  assign w_min_inc = (w_run & w_sec_carry) | (w_set_min & w_inc_act);
  assign w_hr_inc  = (w_run & w_min_carry) | (w_set_hr & w_inc_act);

  bcd_mod_counter #(.MAX(59)) u_seconds (
    .i_clk   (clk_50MHz),
    .i_rst_n (set_n),
    .i_inc   (w_sec_inc),
    .i_clr   (w_sec_clr),
    .o_value (seconds_bcd),
    .o_carry (w_sec_carry)
  );

  bcd_mod_counter #(.MAX(59)) u_minutes (
    .i_clk   (clk_50MHz),
    .i_rst_n (set_n),
    .i_inc   (w_min_inc),
    .i_clr   (1'b0),
    .o_value (minutes_bcd),
    .o_carry (w_min_carry)
  );

  bcd_mod_counter #(.MAX(MAX_HOUR)) u_hours (
    .i_clk   (clk_50MHz),
    .i_rst_n (set_n),
    .i_inc   (w_hr_inc),
    .i_clr   (1'b0),
    .o_value (hours_bcd),
    .o_carry (w_hr_carry_unused)
  );

endmodule

// File: tb/tb_clock_mode_controller.sv
module tb_clock_mode_controller;

  typedef enum int unsigned {OP_TICK, OP_MODE, OP_INC} op_e;

  typedef struct {
    op_e         op;
    int unsigned reps;
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic [1:0]  md;
    logic        bl;
  } vec_t;

  logic       clk = 1'b0;
  logic       set_n = 1'b0;
  logic       tick = 1'b0;
  logic       kmode = 1'b1;
  logic       kinc = 1'b1;
  logic [7:0] hours_bcd, minutes_bcd, seconds_bcd;
  logic [1:0] mode;
  logic       blink, div_set_n;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  clock_mode_controller #(
    .SYNC_STAGES    (2),
    .DIV_CLR_CYCLES (4),
    .MAX_HOUR       (23)
  ) dut (
    .clk_50MHz   (clk),
    .set_n       (set_n),
    .tick_1hz    (tick),
    .key_mode_n  (kmode),
    .key_inc_n   (kinc),
    .hours_bcd   (hours_bcd),
    .minutes_bcd (minutes_bcd),
    .seconds_bcd (seconds_bcd),
    .mode        (mode),
    .blink       (blink),
    .div_set_n   (div_set_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input op_e op, input int unsigned reps, input logic [7:0] hh,
                     input logic [7:0] mm, input logic [7:0] ss, input logic [1:0] md,
                     input logic bl);
    vec_t v;
    v.op = op; v.reps = reps; v.hh = hh; v.mm = mm; v.ss = ss; v.md = md; v.bl = bl;
    vecs.push_back(v);
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic press_mode();
    @(negedge clk) kmode = 1'b0;
    repeat (4) @(negedge clk);
    kmode = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic press_inc();
    @(negedge clk) kinc = 1'b0;
    repeat (4) @(negedge clk);
    kinc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_time(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                            input logic [7:0] ss, input logic [1:0] md, input logic bl);
    check({tag, "_hours"},   hours_bcd,   hh);
    check({tag, "_minutes"}, minutes_bcd, mm);
    check({tag, "_seconds"}, seconds_bcd, ss);
    check({tag, "_mode"},    {6'd0, mode}, {6'd0, md});
    check({tag, "_blink"},   {7'd0, blink}, {7'd0, bl});
  endtask

  initial begin
    int unsigned lowcnt;
    bit          found;

    // Preload to 23:59 via set modes, roll over the day, then set-mode wrap cases
    add(OP_MODE,  1, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_INC,  23, 8'h23, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_TICK,  1, 8'h23, 8'h00, 8'h00, 2'd1, 1'b1);
    add(OP_MODE,  1, 8'h23, 8'h00, 8'h00, 2'd2, 1'b0);
    add(OP_INC,  58, 8'h23, 8'h58, 8'h00, 2'd2, 1'b0);
    add(OP_INC,   1, 8'h23, 8'h59, 8'h00, 2'd2, 1'b0);
    add(OP_INC,   1, 8'h23, 8'h00, 8'h00, 2'd2, 1'b0);
    add(OP_INC,  59, 8'h23, 8'h59, 8'h00, 2'd2, 1'b0);
    add(OP_TICK,  1, 8'h23, 8'h59, 8'h00, 2'd2, 1'b1);
    add(OP_TICK,  1, 8'h23, 8'h59, 8'h00, 2'd2, 1'b0);
    add(OP_MODE,  1, 8'h23, 8'h59, 8'h00, 2'd0, 1'b0);
    add(OP_TICK, 59, 8'h23, 8'h59, 8'h59, 2'd0, 1'b0);
    add(OP_TICK,  1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
    add(OP_TICK,  1, 8'h00, 8'h00, 8'h01, 2'd0, 1'b0);
    add(OP_INC,   1, 8'h00, 8'h00, 8'h01, 2'd0, 1'b0);
    add(OP_MODE,  1, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_INC,  21, 8'h21, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_INC,   1, 8'h22, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_INC,   1, 8'h23, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_INC,   1, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_INC,   1, 8'h01, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_INC,   1, 8'h02, 8'h00, 8'h00, 2'd1, 1'b0);
    add(OP_MODE,  1, 8'h02, 8'h00, 8'h00, 2'd2, 1'b0);
    add(OP_INC,  58, 8'h02, 8'h58, 8'h00, 2'd2, 1'b0);
    add(OP_INC,   1, 8'h02, 8'h59, 8'h00, 2'd2, 1'b0);
    add(OP_INC,   1, 8'h02, 8'h00, 8'h00, 2'd2, 1'b0);
    add(OP_INC,   1, 8'h02, 8'h01, 8'h00, 2'd2, 1'b0);
    add(OP_MODE,  1, 8'h02, 8'h01, 8'h00, 2'd0, 1'b0);
    add(OP_TICK,  1, 8'h02, 8'h01, 8'h01, 2'd0, 1'b0);

    // Reset state and divider hold after release
    repeat (3) @(negedge clk);
    check_time("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
    check("reset_div_set_n", {7'd0, div_set_n}, 8'd0);
    set_n = 1'b1;
    #1 check("release_div0", {7'd0, div_set_n}, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("release_div%0d", k), {7'd0, div_set_n}, (k >= 4) ? 8'd1 : 8'd0);
    end
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      for (int unsigned r = 0; r < vecs[i].reps; r++) begin
        case (vecs[i].op)
          OP_TICK: do_tick();
          OP_MODE: press_mode();
          default: press_inc();
        endcase
      end
      check_time($sformatf("v%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].md, vecs[i].bl);
    end

    // Mode and inc pressed together in RUN: mode wins, inc dropped
    @(negedge clk) begin kmode = 1'b0; kinc = 1'b0; end
    repeat (4) @(negedge clk);
    kmode = 1'b1; kinc = 1'b1;
    repeat (5) @(negedge clk);
    check_time("simul", 8'h02, 8'h01, 8'h00, 2'd1, 1'b0);

    // Set 12:34 in SET_MIN, then asynchronous reset mid-edit
    for (int n = 0; n < 10; n++) press_inc();
    press_mode();
    for (int n = 0; n < 33; n++) press_inc();
    check_time("preset", 8'h12, 8'h34, 8'h00, 2'd2, 1'b0);
    @(negedge clk) set_n = 1'b0;
    #1;
    check_time("async_rst", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
    check("async_rst_div", {7'd0, div_set_n}, 8'd0);
    @(negedge clk) set_n = 1'b1;
    repeat (6) @(negedge clk);
    check("after_rst_div", {7'd0, div_set_n}, 8'd1);

    // SET_MIN -> RUN: count div_set_n low cycles, with a tick landing inside the hold
    press_mode();
    press_mode();
    check("to_set_min", {6'd0, mode}, 8'd2);
    @(negedge clk) kmode = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mode == 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    check("exit_set_min_seen", {7'd0, found}, 8'd1);
    tick = 1'b1;
    lowcnt = 0;
    for (int n = 0; n < 20 && div_set_n == 1'b0; n++) begin
      lowcnt++;
      @(negedge clk);
      tick = 1'b0;
    end
    tick = 1'b0;
    check("div_low_cycles", 8'(lowcnt), 8'd4);
    kmode = 1'b1;
    repeat (10) @(negedge clk);
    check("tick_in_hold_ignored", seconds_bcd, 8'h00);

    // Long holds produce exactly one action each
    @(negedge clk) kmode = 1'b0;
    repeat (1000) @(negedge clk);
    check("hold_mode", {6'd0, mode}, 8'd1);
    kmode = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_mode_rel", {6'd0, mode}, 8'd1);
    @(negedge clk) kinc = 1'b0;
    repeat (1000) @(negedge clk);
    check("hold_inc", hours_bcd, 8'h01);
    kinc = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_inc_rel", hours_bcd, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
